// File: rtl/bip_control_fsm_pkg.sv
// Shared definitions for the BIP multi-cycle control unit: opcodes, datapath
// select/ALU encodings, FSM states and the registered control bundle.
package bip_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_XORI = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b10001;

  localparam logic [1:0] SELA_MEM  = 2'b00;
  localparam logic [1:0] SELA_IMM  = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;
  localparam logic [1:0] SELA_HOLD = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JMP  = 2'd1,
    BR_EQ   = 2'd2,
    BR_NE   = 2'd3
  } branch_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic [2:0] alu_op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
    branch_e    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{sel_a: SELA_HOLD, sel_b: 1'b0, alu_op: ALU_ADD,
                                  wr_acc: 1'b0, rd_ram: 1'b0, wr_ram: 1'b0,
                                  branch: BR_NONE};

  // ALU instructions: immediate form takes B from the operand, memory form reads RAM.
  function automatic ctrl_t alu_ctrl(input logic [2:0] op, input logic imm);
    ctrl_t c;
    c        = CTRL_IDLE;
    c.sel_a  = SELA_ALU;
    c.sel_b  = imm;
    c.alu_op = op;
    c.wr_acc = 1'b1;
    c.rd_ram = ~imm;
    return c;
  endfunction

endpackage

// File: rtl/bip_opcode_rom.sv
// Combinational opcode decode: opcode -> control bundle plus halt/illegal flags.
module bip_opcode_rom
  import bip_control_fsm_pkg::*;
(
  input  logic [4:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       halt_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_IDLE;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_HLT:  halt_o = 1'b1;
      OP_STO:  ctrl_o.wr_ram = 1'b1;
      OP_LD: begin
        ctrl_o.sel_a  = SELA_MEM;
        ctrl_o.rd_ram = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl_o.sel_a  = SELA_IMM;
        ctrl_o.wr_acc = 1'b1;
      end
      OP_ADD:  ctrl_o = alu_ctrl(ALU_ADD, 1'b0);
      OP_ADDI: ctrl_o = alu_ctrl(ALU_ADD, 1'b1);
      OP_SUB:  ctrl_o = alu_ctrl(ALU_SUB, 1'b0);
      OP_SUBI: ctrl_o = alu_ctrl(ALU_SUB, 1'b1);
      OP_AND:  ctrl_o = alu_ctrl(ALU_AND, 1'b0);
      OP_ANDI: ctrl_o = alu_ctrl(ALU_AND, 1'b1);
      OP_OR:   ctrl_o = alu_ctrl(ALU_OR, 1'b0);
      OP_ORI:  ctrl_o = alu_ctrl(ALU_OR, 1'b1);
      OP_XOR:  ctrl_o = alu_ctrl(ALU_XOR, 1'b0);
      OP_XORI: ctrl_o = alu_ctrl(ALU_XOR, 1'b1);
      OP_JMP:  ctrl_o.branch = BR_JMP;
      OP_BEQ:  ctrl_o.branch = BR_EQ;
      OP_BNE:  ctrl_o.branch = BR_NE;
      OP_NOP:  ctrl_o = CTRL_IDLE;
      default: begin
        halt_o    = 1'b1;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bip_control_fsm.sv
// BIP accumulator CPU control unit: owns PC and IR, sequences
// FETCH/DECODE/EXEC/WB against program and data memory.
module bip_control_fsm
  import bip_control_fsm_pkg::*;
#(
  parameter int OPCODE  = 5,
  parameter int OPERAND = 11,
  parameter int PC_W    = 11,
  parameter int CNT_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_Start,
  input  logic                       i_StepMode,
  input  logic [OPCODE+OPERAND-1:0]  i_Instr,
  input  logic                       i_InstrValid,
  input  logic                       i_MemReady,
  input  logic                       i_AccZero,
  output logic [PC_W-1:0]            o_PC,
  output logic                       o_InstrReq,
  output logic [OPERAND-1:0]         o_Operand,
  output logic [1:0]                 o_SelA,
  output logic                       o_SelB,
  output logic [2:0]                 o_AluOp,
  output logic                       o_WrAcc,
  output logic                       o_WrRam,
  output logic                       o_RdRam,
  output logic                       o_Busy,
  output logic                       o_Halted,
  output logic                       o_Illegal,
  output logic [CNT_W-1:0]           o_Retired,
  output logic [2:0]                 o_DbgState
);

  state_e                      state_q, state_d;
  logic [PC_W-1:0]             pc_q, pc_d;
  logic [OPCODE+OPERAND-1:0]   ir_q, ir_d;
  ctrl_t                       ctrl_q, ctrl_d;
  logic [CNT_W-1:0]            retired_q, retired_d;
  logic                        illegal_q, illegal_d;

  ctrl_t rom_ctrl;
  logic  rom_halt;
  logic  rom_illegal;
  logic  in_exec;
  logic  in_wb;
  logic  mem_op;

  bip_opcode_rom u_rom (
    .opcode_i  (ir_q[OPCODE+OPERAND-1 -: OPCODE]),
    .ctrl_o    (rom_ctrl),
    .halt_o    (rom_halt),
    .illegal_o (rom_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      ctrl_q    <= CTRL_IDLE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshakes: a request (o_InstrReq, o_RdRam, o_WrRam) stays high with its
  // address stable until the matching i_InstrValid / i_MemReady is sampled high.
  assign mem_op = ctrl_q.rd_ram | ctrl_q.wr_ram;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ctrl_d    = ctrl_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_InstrValid) begin
          ir_d    = i_Instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (rom_halt) begin
          ctrl_d    = CTRL_IDLE;
          illegal_d = illegal_q | rom_illegal;
          state_d   = ST_HALT;
        end else begin
          ctrl_d  = rom_ctrl;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!mem_op || i_MemReady) state_d = ST_WB;
      end
      ST_WB: begin
        pc_d = pc_q + PC_W'(1);
        case (ctrl_q.branch)
          BR_JMP:  pc_d = ir_q[PC_W-1:0];
          BR_EQ:   if (i_AccZero) pc_d = ir_q[PC_W-1:0];
          BR_NE:   if (!i_AccZero) pc_d = ir_q[PC_W-1:0];
          default: pc_d = pc_q + PC_W'(1);
        endcase
        if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
        state_d = i_StepMode ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // The decoded bundle only drives the datapath while an instruction executes.
  assign in_exec = (state_q == ST_EXEC);
  assign in_wb   = (state_q == ST_WB);

  assign o_PC       = pc_q;
  assign o_InstrReq = (state_q == ST_FETCH);
  assign o_Operand  = ir_q[OPERAND-1:0];
  assign o_SelA     = (in_exec || in_wb) ? ctrl_q.sel_a  : SELA_HOLD;
  assign o_SelB     = (in_exec || in_wb) ? ctrl_q.sel_b  : 1'b0;
  assign o_AluOp    = (in_exec || in_wb) ? ctrl_q.alu_op : ALU_ADD;
  assign o_WrAcc    = in_wb & ctrl_q.wr_acc;
  assign o_RdRam    = in_exec & ctrl_q.rd_ram;
  assign o_WrRam    = in_exec & ctrl_q.wr_ram;
  assign o_Busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) || in_exec || in_wb;
  assign o_Halted   = (state_q == ST_HALT);
  assign o_Illegal  = illegal_q;
  assign o_Retired  = retired_q;
  assign o_DbgState = state_q;

endmodule

// File: tb/tb_bip_control_fsm.sv
// Bench for bip_control_fsm: memory responders with random waits, a retire
// scoreboard, a vector table of single instructions and multi-cycle sequences.
module tb_bip_control_fsm;

  localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [4:0] C_HLT = 5'h00, C_STO = 5'h01, C_LD = 5'h02, C_LDI = 5'h03,
    C_ADD = 5'h04, C_ADDI = 5'h05, C_SUB = 5'h06, C_SUBI = 5'h07, C_AND = 5'h08,
    C_ANDI = 5'h09, C_OR = 5'h0A, C_ORI = 5'h0B, C_XOR = 5'h0C, C_XORI = 5'h0D,
    C_JMP = 5'h0E, C_BEQ = 5'h0F, C_BNE = 5'h10, C_NOP = 5'h11;
  localparam int W = 31;

  logic        clk;
  logic        i_reset, i_Start, i_StepMode, i_InstrValid, i_MemReady, i_AccZero;
  logic [15:0] i_Instr;
  logic [10:0] o_PC, o_Operand;
  logic        o_InstrReq, o_SelB, o_WrAcc, o_WrRam, o_RdRam, o_Busy, o_Halted, o_Illegal;
  logic [1:0]  o_SelA;
  logic [2:0]  o_AluOp, o_DbgState;
  logic [15:0] o_Retired;

  bip_control_fsm dut (
    .i_clk(clk), .i_reset(i_reset), .i_Start(i_Start), .i_StepMode(i_StepMode),
    .i_Instr(i_Instr), .i_InstrValid(i_InstrValid), .i_MemReady(i_MemReady),
    .i_AccZero(i_AccZero), .o_PC(o_PC), .o_InstrReq(o_InstrReq), .o_Operand(o_Operand),
    .o_SelA(o_SelA), .o_SelB(o_SelB), .o_AluOp(o_AluOp), .o_WrAcc(o_WrAcc),
    .o_WrRam(o_WrRam), .o_RdRam(o_RdRam), .o_Busy(o_Busy), .o_Halted(o_Halted),
    .o_Illegal(o_Illegal), .o_Retired(o_Retired), .o_DbgState(o_DbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  prog [0:2047];
  logic [W-1:0] exp_q[$];
  int chk_cnt = 0, pass_cnt = 0;
  int fetch_fix = -1, mem_fix = -1;
  int rd_cycles = 0, wracc_cnt = 0, strobe_cnt = 0, busy_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk_obs(input logic wr_acc, input logic [1:0] sel_a,
      input logic sel_b, input logic [2:0] alu, input logic rd, input logic wr,
      input logic [10:0] operand, input logic [10:0] pc);
    return {wr_acc, sel_a, sel_b, alu, rd, wr, operand, pc};
  endfunction

  // program / data memory responders
  initial begin
    int iw, mw;
    iw = 0; mw = 0;
    i_InstrValid = 1'b0; i_MemReady = 1'b0; i_Instr = '0;
    forever begin
      @(negedge clk);
      if (o_InstrReq) begin
        if (iw == 0) begin i_InstrValid = 1'b1; i_Instr = prog[o_PC]; end
        else begin i_InstrValid = 1'b0; i_Instr = 16'($urandom); iw--; end
      end else begin
        i_InstrValid = 1'b0; i_Instr = 16'($urandom);
        iw = (fetch_fix >= 0) ? fetch_fix : int'($urandom_range(0, 2));
      end
      if (o_RdRam || o_WrRam) begin
        if (mw == 0) i_MemReady = 1'b1;
        else begin i_MemReady = 1'b0; mw--; end
      end else begin
        i_MemReady = 1'b0;
        mw = (mem_fix >= 0) ? mem_fix : int'($urandom_range(0, 2));
      end
    end
  end

  // retire monitor: controls captured in WB, resulting PC one cycle later
  logic [W-12:0] cap;
  logic pending = 1'b0, rd_seen = 1'b0, wr_seen = 1'b0;
  always @(posedge clk) begin
    #2;
    if (pending) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_unexpected got=%h expected=none", {cap, o_PC});
      end else check("sb_retire", {cap, o_PC}, exp_q.pop_front());
    end
    pending = 1'b0;
    if (o_DbgState == 3'd2) begin rd_seen = 1'b0; wr_seen = 1'b0; end
    if (o_DbgState == S_EXEC) begin rd_seen |= o_RdRam; wr_seen |= o_WrRam; end
    if (o_DbgState == S_WB) begin
      cap = {o_WrAcc, o_SelA, o_SelB, o_AluOp, rd_seen, wr_seen, o_Operand};
      pending = 1'b1;
    end
    rd_cycles   += int'(o_RdRam);
    wracc_cnt   += int'(o_WrAcc);
    strobe_cnt  += int'(o_RdRam | o_WrRam | o_WrAcc);
    busy_cycles += int'(o_Busy);
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1; i_Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); i_Start = 1'b1;
    @(negedge clk); i_Start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (o_DbgState != st && n < budget) begin @(negedge clk); n++; end
    if (o_DbgState != st) begin
      chk_cnt++;
      $display("FAIL %s timeout state=%0d expected=%0d", name, o_DbgState, st);
    end
  endtask

  task automatic clear_counts();
    rd_cycles = 0; wracc_cnt = 0; strobe_cnt = 0; busy_cycles = 0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [10:0] operand;
    logic        acc_zero;
    logic [10:0] start_pc;
    logic [10:0] exp_pc;
    logic        wr_acc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [2:0]  alu;
    logic        rd;
    logic        wr;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  initial begin
    i_reset = 1'b1; i_Start = 1'b0; i_StepMode = 1'b0; i_AccZero = 1'b0;
    foreach (prog[a]) prog[a] = '0;

    //            op      opnd    az    start   exp_pc  wa  selA   sB   alu     rd   wr
    vecs.push_back('{C_LDI,  11'h005, 1'b0, 11'h000, 11'h001, 1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_ADDI, 11'h003, 1'b0, 11'h055, 11'h056, 1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_LD,   11'h020, 1'b0, 11'h000, 11'h001, 1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0});
    vecs.push_back('{C_STO,  11'h010, 1'b0, 11'h200, 11'h201, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b1});
    vecs.push_back('{C_ADD,  11'h005, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b0, 3'b000, 1'b1, 1'b0});
    vecs.push_back('{C_SUB,  11'h006, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b0, 3'b001, 1'b1, 1'b0});
    vecs.push_back('{C_SUBI, 11'h7FF, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b1, 3'b001, 1'b0, 1'b0});
    vecs.push_back('{C_AND,  11'h0AA, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b0, 3'b010, 1'b1, 1'b0});
    vecs.push_back('{C_ANDI, 11'h0F0, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0});
    vecs.push_back('{C_OR,   11'h123, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b0, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{C_ORI,  11'h456, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b1, 3'b011, 1'b0, 1'b0});
    vecs.push_back('{C_XOR,  11'h3FF, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b0, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{C_XORI, 11'h001, 1'b0, 11'h000, 11'h001, 1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 1'b0});
    vecs.push_back('{C_JMP,  11'h040, 1'b0, 11'h000, 11'h040, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_BEQ,  11'h040, 1'b1, 11'h100, 11'h040, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_BEQ,  11'h040, 1'b0, 11'h100, 11'h101, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_BNE,  11'h040, 1'b0, 11'h100, 11'h040, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_BNE,  11'h040, 1'b1, 11'h100, 11'h101, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_JMP,  11'h000, 1'b0, 11'h7FF, 11'h000, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_NOP,  11'h000, 1'b0, 11'h7FF, 11'h000, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
    vecs.push_back('{C_NOP,  11'h3AB, 1'b0, 11'h010, 11'h011, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});

    // reset state
    do_reset();
    check("reset_state",
          {o_DbgState, o_PC, o_Retired, o_Illegal, o_InstrReq, o_SelA, o_SelB, o_AluOp,
           o_WrAcc, o_WrRam, o_RdRam, o_Busy, o_Halted, o_Operand},
          {S_IDLE, 11'h000, 16'h0000, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000});

    // single-instruction vectors in step mode, random memory waits
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      do_reset();
      i_StepMode = 1'b1;
      i_AccZero  = v.acc_zero;
      if (v.start_pc != 11'h000) begin
        prog[0] = {C_JMP, v.start_pc};
        exp_q.push_back(mk_obs(1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0, v.start_pc, v.start_pc));
        pulse_start();
        wait_state(S_IDLE, 200, "vec_jmp_idle");
      end
      prog[v.start_pc] = {v.op, v.operand};
      exp_q.push_back(mk_obs(v.wr_acc, v.sel_a, v.sel_b, v.alu, v.rd, v.wr, v.operand, v.exp_pc));
      pulse_start();
      wait_state(S_IDLE, 200, "vec_idle");
      check("vec_retired", o_Retired, (v.start_pc != 11'h000) ? 2 : 1);
    end

    // program LDI 5; ADDI 3; STO 0x010; HLT with zero-wait memories
    do_reset();
    fetch_fix = 0; mem_fix = 0; i_StepMode = 1'b0;
    prog[0] = {C_LDI, 11'h005}; prog[1] = {C_ADDI, 11'h003};
    prog[2] = {C_STO, 11'h010}; prog[3] = {C_HLT, 11'h000};
    exp_q.push_back(mk_obs(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 11'h005, 11'h001));
    exp_q.push_back(mk_obs(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 11'h003, 11'h002));
    exp_q.push_back(mk_obs(1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b1, 11'h010, 11'h003));
    clear_counts();
    pulse_start();
    wait_state(S_HALT, 100, "prog_halt");
    check("prog_retired", o_Retired, 16'd3);
    check("prog_pc", o_PC, 11'h003);
    check("prog_flags", {o_Halted, o_Illegal, o_Busy}, 3'b100);
    check("prog_busy_cycles", busy_cycles, 14);

    // LD with data memory ready delayed 3 cycles
    do_reset();
    fetch_fix = -1; mem_fix = 3; i_StepMode = 1'b1;
    prog[0] = {C_LD, 11'h020};
    exp_q.push_back(mk_obs(1'b1, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 11'h020, 11'h001));
    clear_counts();
    pulse_start();
    wait_state(S_IDLE, 100, "ld_wait_idle");
    check("ld_rd_cycles", rd_cycles, 4);
    check("ld_wracc_pulses", wracc_cnt, 1);

    // undefined opcode traps, ignores start, clears on reset
    do_reset();
    mem_fix = -1; i_StepMode = 1'b0;
    prog[0] = {5'b11111, 11'h155};
    clear_counts();
    pulse_start();
    wait_state(S_HALT, 100, "illegal_halt");
    check("illegal_flags", {o_Illegal, o_Halted, o_Busy}, 3'b110);
    check("illegal_strobes", strobe_cnt, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    check("illegal_start_ignored", {o_DbgState, o_PC, o_Retired, o_Illegal},
          {S_HALT, 11'h000, 16'h0000, 1'b1});
    do_reset();
    check("illegal_reset_clears", {o_DbgState, o_Illegal, o_Halted}, {S_IDLE, 1'b0, 1'b0});

    // step mode: one start pulse retires one instruction; start while busy ignored
    i_StepMode = 1'b1;
    prog[0] = {C_LDI, 11'h001}; prog[1] = {C_LDI, 11'h002}; prog[2] = {C_LDI, 11'h003};
    exp_q.push_back(mk_obs(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 11'h001, 11'h001));
    exp_q.push_back(mk_obs(1'b1, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 11'h002, 11'h002));
    pulse_start();
    @(negedge clk);
    pulse_start();
    wait_state(S_IDLE, 100, "step1_idle");
    repeat (4) @(negedge clk);
    check("step1", {o_DbgState, o_Retired, o_PC}, {S_IDLE, 16'd1, 11'h001});
    pulse_start();
    wait_state(S_IDLE, 100, "step2_idle");
    repeat (4) @(negedge clk);
    check("step2", {o_DbgState, o_Retired, o_PC}, {S_IDLE, 16'd2, 11'h002});

    // reset during a pending data read aborts without accumulator write
    do_reset();
    mem_fix = 10; i_StepMode = 1'b0;
    prog[0] = {C_LD, 11'h020};
    pulse_start();
    wait_state(S_EXEC, 100, "abort_exec");
    check("abort_rdram", o_RdRam, 1'b1);
    clear_counts();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("abort_state", {o_DbgState, o_PC, o_Retired, o_RdRam}, {S_IDLE, 11'h000, 16'h0000, 1'b0});
    repeat (3) @(negedge clk);
    check("abort_no_wracc", {wracc_cnt, o_DbgState}, {32'd0, S_IDLE});

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bip_control_fsm.md
Name: bip_control_fsm

Overview:
- Multi-cycle control unit for the BIP accumulator CPU; next generation of the combinational opcode decoder.
- Owns PC and instruction register; sequences FETCH/DECODE/EXEC/WB with ready/valid handshakes to program and data memory.
- Adds logic ops, branches, single-step debug mode and an illegal-opcode trap.
- Sits between program memory, data memory and the datapath (acc, ALU, muxes A/B).

Parameters:
- OPCODE, 5, opcode field width (instruction MSBs).
- OPERAND, 11, operand/address field width (instruction LSBs).
- PC_W, 11, program counter width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_Start  in  1  run pulse; leaves IDLE.
- i_StepMode  in  1  1 = return to IDLE after each retired instruction.
- i_Instr  in  OPCODE+OPERAND  program memory read data.
- i_InstrValid  in  1  i_Instr valid this cycle.
- i_MemReady  in  1  data memory access completes this cycle.
- i_AccZero  in  1  accumulator == 0 (datapath flag).
- o_PC  out  PC_W  program memory address.
- o_InstrReq  out  1  fetch request.
- o_Operand  out  OPERAND  IR operand: immediate or data address.
- o_SelA  out  2  acc input mux: 00 mem, 01 imm, 10 ALU, 11 hold.
- o_SelB  out  1  ALU B: 0 mem, 1 imm.
- o_AluOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor.
- o_WrAcc  out  1  accumulator write strobe.
- o_WrRam  out  1  data memory write request.
- o_RdRam  out  1  data memory read request.
- o_Busy  out  1  high in FETCH/DECODE/EXEC/WB.
- o_Halted  out  1  in HALT state.
- o_Illegal  out  1  sticky; halted due to undefined opcode.
- o_Retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state IDLE; PC=0; IR=0; o_Retired=0; o_Illegal=0. All strobes/requests 0, o_SelA=11, o_SelB=0, o_AluOp=000. Reset mid-instruction aborts it with no acc/RAM write.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: wait for i_Start=1, then FETCH.
- FETCH: o_InstrReq=1 and o_PC stable until i_InstrValid; that cycle IR<=i_Instr, next DECODE. Wait cycles are unbounded.
- DECODE: register the control bundle from the IR opcode; it holds stable through EXEC and WB.
- EXEC, memory ops (LD, ADD, SUB, AND, OR, XOR): o_RdRam=1 until i_MemReady. STO: o_WrRam=1 until i_MemReady. Other ops take one EXEC cycle.
- WB: o_WrAcc=1 for exactly one cycle for acc-writing ops.
  - PC update: PC<=PC+1, modulo 2^PC_W, wrapping from max to 0.
  - JMP: PC<=operand[PC_W-1:0].
  - BEQ: PC<=operand if i_AccZero, sampled in WB. BNE: the inverse.
  - o_Retired saturates at all-ones.
  - Next state: IDLE if i_StepMode, else FETCH.
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, AND 01000, ANDI 01001, OR 01010, ORI 01011, XOR 01100, XORI 01101, JMP 01110, BEQ 01111, BNE 10000, NOP 10001. All other codes are undefined.
- HLT: in DECODE go to HALT; PC is not advanced and the instruction is not counted.
- Undefined opcode: same as HLT, and o_Illegal<=1.
- HALT: o_Halted=1; i_Start is ignored; exit only by reset.
- Latency: a non-memory instruction with zero-wait fetch is 4 cycles from FETCH entry to next FETCH.
- Simultaneous events: i_Start while busy is ignored. i_StepMode is sampled only in WB.

Decomposition:
- Shared include bip_defs.vh: opcode defines, SelA/AluOp encodings, state encodings.
- One sub-module, bip_opcode_rom: combinational opcode -> control bundle plus is_mem/is_branch/illegal flags. The FSM instantiates it and registers its outputs in DECODE.

Test Plan:
- Program LDI 5; ADDI 3; STO 0x010; HLT with zero-wait memories -> o_WrRam in 3rd instruction with o_Operand=0x010; HALT reached; o_Retired=3; PC=3.
- LD 0x020 with i_MemReady delayed 3 cycles -> o_RdRam held 4 cycles; single o_WrAcc pulse in WB with SelA=00.
- BEQ 0x040 with i_AccZero=1 -> PC=0x040. Same with i_AccZero=0 -> PC=old+1. JMP at PC=0x7FF with operand 0 -> PC=0.
- NOP at PC=0x7FF -> PC wraps to 0x000.
- Opcode 11111 -> o_Illegal=1, o_Halted=1, no strobes; a later i_Start has no effect; i_reset clears all.
- i_StepMode=1 -> returns to IDLE after each WB; one i_Start pulse retires exactly one instruction. Reset asserted in EXEC with o_RdRam high -> next cycle IDLE, PC=0, no o_WrAcc.
